// File: rtl/ula_const_seq.sv
//------------------------------------------------------------------------------
// ula_const_seq
//
// Constant-operation unit. It sits between decode/operand fetch and the
// register-file writeback mux. The output is registered, and both sides use a
// valid/ready handshake.
//
// Operations (formato):
//   00  resultOP = dado
//   01  resultOP = constante
//   10  resultOP = dado with one lane replaced by constante[LANE_BITS-1:0]
//   11  accumulate one lane-sized immediate. The first chunk lands in the most
//       significant lane, and the word is presented after LANES beats.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   in_valid/in_ready   input handshake; in_ready = !out_valid || out_ready
//   formato             operation select (see above)
//   dado, constante     operands A and B
//   lane                target lane for op 10 (lane 0 = LSBs, clamped)
//   seq_start           with op 11: restart the accumulation at chunk 0
//   out_valid/out_ready output handshake
//   resultOP            registered result
//   seq_abort           one-cycle pulse when a partial word is dropped by
//                       an op other than 11
//   res_zero, res_neg   result flags. They are live only when the macro
//                       ULA_CONST_FLAGS_EN is defined; otherwise they are 0.
//
// Optional feature macro: ULA_CONST_FLAGS_EN
//------------------------------------------------------------------------------
module ula_const_seq #(
   parameter int WORD_BITS     = 16,
   parameter int LANE_BITS     = 8,
   parameter int LANES         = WORD_BITS / LANE_BITS,
   parameter int LANE_IDX_BITS = (LANES > 1) ? $clog2(LANES) : 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [1:0]               formato,
   input  logic [WORD_BITS-1:0]     dado,
   input  logic [WORD_BITS-1:0]     constante,
   input  logic [LANE_IDX_BITS-1:0] lane,
   input  logic                     seq_start,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [WORD_BITS-1:0]     resultOP,
   output logic                     seq_abort,
   output logic                     res_zero,
   output logic                     res_neg
);

   // Only the low WORD_BITS-LANE_BITS bits of the partial word matter.
   // The top lane is always shifted out by the next beat, or it is the
   // final word, which goes straight to resultOP.
   localparam int ACC_BITS = WORD_BITS - LANE_BITS;
   localparam logic [LANE_IDX_BITS-1:0] LAST_CNT = LANE_IDX_BITS'(LANES - 1);

   localparam logic [1:0] OP_PASS_A   = 2'b00;
   localparam logic [1:0] OP_PASS_B   = 2'b01;
   localparam logic [1:0] OP_INSERT   = 2'b10;
   localparam logic [1:0] OP_ACCUM    = 2'b11;

   // Out-of-range lane indices saturate to the top lane.
   function automatic int clamp_lane(input logic [LANE_IDX_BITS-1:0] sel);
      int s;
      s = int'(sel);
      return (s >= LANES) ? (LANES - 1) : s;
   endfunction

   logic                     out_valid_q, out_valid_d;
   logic [WORD_BITS-1:0]     result_q, result_d;
   logic                     seq_abort_q, seq_abort_d;
   logic [ACC_BITS-1:0]      acc_q, acc_d;
   logic [LANE_IDX_BITS-1:0] cnt_q, cnt_d;

   logic                     accept;
   logic                     load_res;
   logic [WORD_BITS-1:0]     new_res;
   logic [ACC_BITS-1:0]      shift_acc;
   logic [LANE_IDX_BITS-1:0] shift_cnt;
   logic [WORD_BITS-1:0]     shifted;
   logic [WORD_BITS-1:0]     inserted;
   int                       ins_lane;

   assign in_ready  = !out_valid_q || out_ready;
   assign accept    = in_valid && in_ready;
   assign out_valid = out_valid_q;
   assign resultOP  = result_q;
   assign seq_abort = seq_abort_q;

   always_comb begin
      // seq_start makes this beat chunk 0, regardless of any partial word.
      shift_acc = seq_start ? '0 : acc_q;
      shift_cnt = seq_start ? '0 : cnt_q;
      shifted   = {shift_acc, constante[LANE_BITS-1:0]};

      ins_lane = clamp_lane(lane);
      inserted = dado;
      for (int i = 0; i < LANES; i++) begin
         if (i == ins_lane) begin
            inserted[i*LANE_BITS +: LANE_BITS] = constante[LANE_BITS-1:0];
         end
      end

      out_valid_d = out_valid_q && !out_ready;
      seq_abort_d = 1'b0;
      acc_d       = acc_q;
      cnt_d       = cnt_q;
      load_res    = 1'b0;
      new_res     = result_q;

      if (accept) begin
         if (formato == OP_ACCUM) begin
            if (shift_cnt == LAST_CNT) begin
               load_res = 1'b1;
               new_res  = shifted;
               acc_d    = '0;
               cnt_d    = '0;
            end else begin
               // Non-final beat: no result is produced, so out_valid only
               // follows the handshake.
               acc_d = shifted[ACC_BITS-1:0];
               cnt_d = shift_cnt + LANE_IDX_BITS'(1);
            end
         end else begin
            load_res = 1'b1;
            case (formato)
               OP_PASS_A: new_res = dado;
               OP_PASS_B: new_res = constante;
               default:   new_res = inserted;
            endcase
            seq_abort_d = (cnt_q != '0);
            acc_d       = '0;
            cnt_d       = '0;
         end
      end

      if (load_res) begin
         out_valid_d = 1'b1;
      end
      result_d = load_res ? new_res : result_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         result_q    <= '0;
         seq_abort_q <= 1'b0;
         acc_q       <= '0;
         cnt_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         result_q    <= result_d;
         seq_abort_q <= seq_abort_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
      end
   end

`ifdef ULA_CONST_FLAGS_EN
   // The flags are captured only when a new result is loaded, so they stay
   // paired with resultOP while it is held. That includes the reset value,
   // where the flags are 0 even though resultOP is 0.
   logic zero_q, zero_d;
   logic neg_q, neg_d;

   always_comb begin
      zero_d = zero_q;
      neg_d  = neg_q;
      if (load_res) begin
         zero_d = (new_res == '0);
         neg_d  = new_res[WORD_BITS-1];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         zero_q <= 1'b0;
         neg_q  <= 1'b0;
      end else begin
         zero_q <= zero_d;
         neg_q  <= neg_d;
      end
   end

   assign res_zero = zero_q;
   assign res_neg  = neg_q;
`else
   assign res_zero = 1'b0;
   assign res_neg  = 1'b0;
`endif

endmodule

// File: tb/tb_ula_const_seq.sv
//------------------------------------------------------------------------------
// tb_ula_const_seq
//
// Directed testbench for ula_const_seq (16-bit word, 8-bit lanes).
// The stimulus process pushes each expected result into a scoreboard queue.
// A separate monitor pops an entry for every result the consumer takes.
// Inputs change 2 time units after the rising edge. Outputs are sampled on
// the falling edge.
//------------------------------------------------------------------------------
module tb_ula_const_seq;

   typedef struct packed {
      logic [15:0] r;
      logic        z;
      logic        n;
   } exp_t;

   logic        clock;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [1:0]  formato;
   logic [15:0] dado;
   logic [15:0] constante;
   logic [0:0]  lane;
   logic        seq_start;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] resultOP;
   logic        seq_abort;
   logic        res_zero;
   logic        res_neg;

   int   checks   = 0;
   int   failures = 0;
   exp_t sb[$];
   exp_t mon_e;

   ula_const_seq #(.WORD_BITS(16), .LANE_BITS(8)) dut (
      .clock     (clock),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .formato   (formato),
      .dado      (dado),
      .constante (constante),
      .lane      (lane),
      .seq_start (seq_start),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .resultOP  (resultOP),
      .seq_abort (seq_abort),
      .res_zero  (res_zero),
      .res_neg   (res_neg)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic push(input logic [15:0] v);
      exp_t e;
      e.r = v;
`ifdef ULA_CONST_FLAGS_EN
      e.z = (v == 16'h0000);
      e.n = v[15];
`else
      e.z = 1'b0;
      e.n = 1'b0;
`endif
      sb.push_back(e);
   endtask

   // Present one operation for one cycle. It is accepted on the next rising edge.
   task automatic drive(input logic [1:0] f, input logic [15:0] d, input logic [15:0] c,
                        input logic ln, input logic st);
      @(posedge clock);
      #2;
      formato   = f;
      dado      = d;
      constante = c;
      lane      = ln;
      seq_start = st;
      in_valid  = 1'b1;
   endtask

   task automatic idle();
      @(posedge clock);
      #2;
      in_valid  = 1'b0;
      seq_start = 1'b0;
   endtask

   // Scoreboard monitor: one entry is consumed per handshake.
   always @(negedge clock) begin
      if (!reset && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual=%h required=none", resultOP);
         end else begin
            mon_e = sb.pop_front();
            chk("resultOP", 32'(resultOP), 32'(mon_e.r));
            chk("res_zero", 32'(res_zero), 32'(mon_e.z));
            chk("res_neg",  32'(res_neg),  32'(mon_e.n));
         end
      end
   end

   initial begin
      reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      formato = 2'b00; dado = '0; constante = '0; lane = '0; seq_start = 1'b0;
      repeat (3) @(posedge clock);
      #2 reset = 1'b0;

      // Reset state
      @(negedge clock);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_resultOP",  32'(resultOP),  32'd0);
      chk("rst_seq_abort", 32'(seq_abort), 32'd0);
      chk("rst_res_zero",  32'(res_zero),  32'd0);
      chk("rst_res_neg",   32'(res_neg),   32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd1);

      // Pass the constant
      push(16'hBEEF); drive(2'b01, 16'h0000, 16'hBEEF, 1'b0, 1'b0); idle();
      @(negedge clock);
      chk("beef_valid",    32'(out_valid), 32'd1);
      chk("beef_in_ready", 32'(in_ready),  32'd1);

      // Lane insert, back to back
      push(16'h12AB); drive(2'b10, 16'h1234, 16'h00AB, 1'b0, 1'b0);
      push(16'hAB34); drive(2'b10, 16'h1234, 16'h00AB, 1'b1, 1'b0);
      idle();

      // Two-beat accumulation
      drive(2'b11, 16'h0000, 16'h00CA, 1'b0, 1'b1); idle();
      @(negedge clock);
      chk("beat1_no_out", 32'(out_valid), 32'd0);
      push(16'hCAFE); drive(2'b11, 16'h0000, 16'h00FE, 1'b0, 1'b0); idle();

      // Partial word aborted by op 00
      drive(2'b11, 16'h0000, 16'h0055, 1'b0, 1'b1); idle();
      push(16'h0F0F); drive(2'b00, 16'h0F0F, 16'h0000, 1'b0, 1'b0); idle();
      @(negedge clock);
      chk("abort_pulse", 32'(seq_abort), 32'd1);
      @(negedge clock);
      chk("abort_once",  32'(seq_abort), 32'd0);
      drive(2'b11, 16'h0000, 16'h0012, 1'b0, 1'b0);
      push(16'h1234); drive(2'b11, 16'h0000, 16'h0034, 1'b0, 1'b0); idle();

      // seq_start mid-sequence restarts silently
      drive(2'b11, 16'h0000, 16'h0077, 1'b0, 1'b1);
      drive(2'b11, 16'h0000, 16'h00AA, 1'b0, 1'b1); idle();
      @(negedge clock);
      chk("restart_no_abort", 32'(seq_abort), 32'd0);
      chk("restart_no_out",   32'(out_valid), 32'd0);
      push(16'hAABB); drive(2'b11, 16'h0000, 16'h00BB, 1'b0, 1'b0); idle();

      // Backpressure
      @(posedge clock); #2;
      out_ready = 1'b0;
      push(16'h0001);
      formato = 2'b01; constante = 16'h0001; in_valid = 1'b1;
      @(posedge clock); #2;
      constante = 16'h0003;
      @(negedge clock);
      chk("bp_valid",    32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready),  32'd0);
      chk("bp_result",   32'(resultOP),  32'h0001);
      @(negedge clock);
      chk("bp_held",     32'(resultOP),  32'h0001);
      @(posedge clock); #2;
      push(16'h0002);
      constante = 16'h0002; out_ready = 1'b1;
      @(posedge clock); #2;
      in_valid = 1'b0;
      @(negedge clock);
      chk("nobubble_valid",  32'(out_valid), 32'd1);
      chk("nobubble_result", 32'(resultOP),  32'h0002);

      // Flags
      push(16'h8000); drive(2'b01, 16'h0000, 16'h8000, 1'b0, 1'b0);
      push(16'h0000); drive(2'b01, 16'h0000, 16'h0000, 1'b0, 1'b0);
      idle();

      // Reset during accumulation clears the beat count
      drive(2'b11, 16'h0000, 16'h0099, 1'b0, 1'b1); idle();
      @(posedge clock); #2 reset = 1'b1;
      @(posedge clock); #2 reset = 1'b0;
      drive(2'b11, 16'h0000, 16'h0042, 1'b0, 1'b0); idle();
      @(negedge clock);
      chk("rst_mid_no_out", 32'(out_valid), 32'd0);
      push(16'h4243); drive(2'b11, 16'h0000, 16'h0043, 1'b0, 1'b0); idle();

      repeat (4) @(posedge clock);
      @(negedge clock);
      chk("sb_drained", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
